partial_store_unit: RTL and testbench
=====================================

Name: partial_store_unit

Overview:
- Parametrised, registered store-alignment unit placed between the execute stage and data memory.
- Takes a RISC-V store (funct3, byte address, register data) over a valid/ready request port.
- Emits one or two aligned memory write beats, each with a per-byte write mask, over a valid/ready memory port.
- Supports 32- or 64-bit datapaths, SD when 64-bit, and splitting of misaligned stores across two words.

Parameters:
- XLEN, 32, datapath width in bits; legal values 32 or 64. NB = XLEN/8 bytes per word, OFS_W = log2(NB).
- ADDR_W, 10, byte-address width of ReqAddr and MemAddress.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  store request valid.
- ReqReady  out  1  unit can accept a request.
- ReqFunct3  in  3  store funct3 (Instruction[14:12]).
- ReqAddr  in  ADDR_W  byte address of the store.
- ReqData  in  XLEN  register data to store.
- ReqErr  out  1  one-cycle pulse: request rejected, no memory write issued.
- MemValid  out  1  write beat valid.
- MemReady  in  1  memory accepts the beat.
- MemAddress  out  ADDR_W  word-aligned address; low OFS_W bits always 0.
- MemWriteMask  out  NB  byte write enables.
- DataToMem  out  XLEN  byte-lane-aligned write data.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: ReqReady=1 after release; MemValid=0, MemWriteMask=0, DataToMem=0, MemAddress=0, ReqErr=0, Busy=0.
- States: IDLE, BEAT0, BEAT1.
- ReqReady=1 only in IDLE. A request is accepted on ReqValid&&ReqReady.
- Size field: funct3[1:0] selects 0=byte, 1=half, 2=word, 3=double. Double is legal only when XLEN=64.
- Illegal request: funct3[2]=1, or a size wider than XLEN. Response: ReqErr pulses the cycle after accept, state stays IDLE, MemValid stays 0.
- Beat computation on accept, with off=ReqAddr[OFS_W-1:0]:
  - sh = zero-extended data of the selected size, in 2*XLEN bits, shifted left by 8*off.
  - m = ((1<<bytes)-1)<<off, in 2*NB bits.
  - Beat0 = {sh[XLEN-1:0], m[NB-1:0]} at address ReqAddr with low OFS_W bits cleared.
  - Beat1 = upper halves of sh and m at (beat0 address + NB), wrapping modulo 2^ADDR_W.
  - Upper-half data and mask are latched in internal registers.
- Transitions:
  - IDLE -> BEAT0 on a legal accept. MemValid rises the next cycle (latency 1).
  - BEAT0 -> BEAT1 on MemValid&&MemReady when m[2*NB-1:NB]!=0; otherwise BEAT0 -> IDLE.
  - BEAT1 -> IDLE on MemValid&&MemReady.
- Memory-port stability: MemValid stays 1 in BEAT0/BEAT1. MemAddress, MemWriteMask and DataToMem remain constant until the beat is accepted.
- Beat1 update: outputs switch to beat1 values in the cycle after the beat0 handshake, with MemValid held high and no gap cycle.
- Return to IDLE: outputs clear to 0 and ReqReady rises in the same cycle as the IDLE entry. Maximum throughput is one single-beat store every 2 cycles.
- Aligned accesses never produce a beat1.
- Reset asserted mid-BEAT0 or mid-BEAT1 aborts immediately. MemValid drops asynchronously and the pending beat is discarded.

Optional Feature:
- Macro: PSU_MISALIGN_SPLIT_EN.
- Defined: misaligned stores that straddle a word boundary are split into two beats as described above.
- Undefined: any request with nonzero upper mask half is rejected. ReqErr pulses, no beat is issued, state stays IDLE, and the BEAT1 state and upper-half registers are not built.

Test Plan (XLEN=32, ADDR_W=10):
- SB addr 0x003, data 0x12345678 -> single beat: MemAddress 0x000, mask 4'b1000, DataToMem 0x78000000, then IDLE.
- SH addr 0x002, data 0xAABBCCDD, MemReady low 5 cycles then high -> MemValid held with mask 4'b1100 and data 0xCCDD0000 stable all 6 cycles; ReqReady returns the cycle after the handshake.
- SW addr 0x006, data 0x11223344, macro defined, MemReady=1 -> beat0 addr 0x004, mask 1100, data 0x33440000; next cycle beat1 addr 0x008, mask 0011, data 0x00001122.
- Same SW with macro undefined -> ReqErr 1-cycle pulse, MemValid never asserted; funct3=3'b011 (SD) -> ReqErr likewise.
- SW addr 0x3FE, macro defined -> beat1 MemAddress wraps to 0x000 with mask 0011.
- rst_n low during beat1 with MemReady=0 -> MemValid=0 immediately; after release ReqReady=1 and Busy=0.

Source files
------------

// File: rtl/partial_store_unit.sv
// partial_store_unit: registered store-alignment stage between execute and data memory.
// Turns a RISC-V store (funct3, byte address, register data) into one or two
// word-aligned write beats carrying a per-byte write mask.
// Optional feature macro: PSU_MISALIGN_SPLIT_EN. When defined, stores that straddle
// a word boundary are split into two beats. When undefined, such stores are
// rejected with ReqErr, and neither the BEAT1 state nor the upper-half registers exist.
module partial_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [2:0]          ReqFunct3,
  input  logic [ADDR_W-1:0]   ReqAddr,
  input  logic [XLEN-1:0]     ReqData,
  output logic                ReqErr,
  output logic                MemValid,
  input  logic                MemReady,
  output logic [ADDR_W-1:0]   MemAddress,
  output logic [XLEN/8-1:0]   MemWriteMask,
  output logic [XLEN-1:0]     DataToMem,
  output logic                Busy
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);
`ifdef PSU_MISALIGN_SPLIT_EN
  localparam int SH_W  = 2 * XLEN;
`else
  localparam int SH_W  = XLEN;
`endif

`ifdef PSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT0} state_t;
`endif

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_p1;
  logic [NB-1:0]     mask_p1;
  logic [XLEN-1:0]   data_p1;
  logic              err_p1;
`ifdef PSU_MISALIGN_SPLIT_EN
  logic [NB-1:0]     hi_mask_p1;
  logic [XLEN-1:0]   hi_data_p1;
`endif

  logic [1:0]        size;
  logic [SH_W-1:0]   sh;
  logic [2*NB-1:0]   m;
  logic              illegal;
  logic              accept;

  // Keeps only the bytes of the register that the store size covers.
  function automatic logic [XLEN-1:0] size_data_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return XLEN'(8'hFF);
      2'd1:    return XLEN'(16'hFFFF);
      2'd2:    return XLEN'(32'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  // Unshifted byte-enable pattern for a store size.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  assign size   = ReqFunct3[1:0];
  assign accept = ReqValid && ReqReady;

  // Decode the incoming store into lane-shifted data/mask and a legality flag.
  always_comb begin
    sh      = SH_W'(ReqData & size_data_mask(size)) << {ReqAddr[OFS_W-1:0], 3'b000};
    m       = (2*NB)'(size_byte_mask(size)) << ReqAddr[OFS_W-1:0];
    illegal = ReqFunct3[2] || ((XLEN == 32) && (size == 2'd3));
`ifndef PSU_MISALIGN_SPLIT_EN
    illegal = illegal || (m[2*NB-1:NB] != '0);
`endif
  end

  // State register; reset aborts any pending beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept && !illegal) next_state = BEAT0;
`ifdef PSU_MISALIGN_SPLIT_EN
      BEAT0: if (MemReady) next_state = (hi_mask_p1 != '0) ? BEAT1 : IDLE;
      BEAT1: if (MemReady) next_state = IDLE;
`else
      BEAT0: if (MemReady) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ReqReady = (state == IDLE);
    MemValid = (state != IDLE);
    Busy     = (state != IDLE);
  end

  // Beat registers: load beat0 on accept, swap in beat1 or clear on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1    <= '0;
      mask_p1    <= '0;
      data_p1    <= '0;
      err_p1     <= 1'b0;
`ifdef PSU_MISALIGN_SPLIT_EN
      hi_mask_p1 <= '0;
      hi_data_p1 <= '0;
`endif
    end else begin
      err_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_p1 <= 1'b1;
            end else begin
              addr_p1    <= {ReqAddr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
              mask_p1    <= m[NB-1:0];
              data_p1    <= sh[XLEN-1:0];
`ifdef PSU_MISALIGN_SPLIT_EN
              hi_mask_p1 <= m[2*NB-1:NB];
              hi_data_p1 <= sh[2*XLEN-1:XLEN];
`endif
            end
          end
        end
        BEAT0: begin
          if (MemReady) begin
`ifdef PSU_MISALIGN_SPLIT_EN
            if (hi_mask_p1 != '0) begin
              addr_p1 <= addr_p1 + ADDR_W'(NB);
              mask_p1 <= hi_mask_p1;
              data_p1 <= hi_data_p1;
            end else begin
              addr_p1 <= '0;
              mask_p1 <= '0;
              data_p1 <= '0;
            end
`else
            addr_p1 <= '0;
            mask_p1 <= '0;
            data_p1 <= '0;
`endif
          end
        end
        default: begin
          if (MemReady) begin
            addr_p1 <= '0;
            mask_p1 <= '0;
            data_p1 <= '0;
          end
        end
      endcase
    end
  end

  assign MemAddress   = addr_p1;
  assign MemWriteMask = mask_p1;
  assign DataToMem    = data_p1;
  assign ReqErr       = err_p1;

endmodule

// File: tb/tb_partial_store_unit.sv
// tb_partial_store_unit: scoreboard bench for partial_store_unit (XLEN=32, ADDR_W=10).
// Expectations follow PSU_MISALIGN_SPLIT_EN the same way the design build does.
module tb_partial_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic        req_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [9:0]  mem_address;
  logic [3:0]  mem_write_mask;
  logic [31:0] data_to_mem;
  logic        busy;

  logic        ready_set = 1'b1;
  logic        rand_mode = 1'b0;
  logic        rnd = 1'b0;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  beat_t beat_q[$];
  int    err_pending = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  assign mem_ready = rand_mode ? rnd : ready_set;

  partial_store_unit #(.XLEN(32), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqFunct3(req_funct3), .ReqAddr(req_addr), .ReqData(req_data),
    .ReqErr(req_err),
    .MemValid(mem_valid), .MemReady(mem_ready),
    .MemAddress(mem_address), .MemWriteMask(mem_write_mask),
    .DataToMem(data_to_mem), .Busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rnd <= 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Byte-by-byte reference model: places each stored byte at its lane.
  task automatic push_expected(input logic [2:0] f3, input logic [9:0] addr, input logic [31:0] data);
    int    nbytes;
    int    off;
    bit    straddle;
    bit    bad;
    int    pos;
    beat_t b0;
    beat_t b1;
    nbytes   = 1 << f3[1:0];
    off      = int'(addr[1:0]);
    straddle = (off + nbytes) > 4;
    bad      = f3[2] || (nbytes > 4);
`ifndef PSU_MISALIGN_SPLIT_EN
    bad = bad || straddle;
`endif
    if (bad) begin
      err_pending++;
      return;
    end
    b0.addr = addr & 10'h3FC;
    b0.mask = '0;
    b0.data = '0;
    b1.addr = b0.addr + 10'd4;
    b1.mask = '0;
    b1.data = '0;
    for (int b = 0; b < nbytes; b++) begin
      pos = off + b;
      if (pos < 4) begin
        b0.mask[pos] = 1'b1;
        b0.data[8*pos +: 8] = data[8*b +: 8];
      end else begin
        b1.mask[pos-4] = 1'b1;
        b1.data[8*(pos-4) +: 8] = data[8*b +: 8];
      end
    end
    beat_q.push_back(b0);
    if (straddle) beat_q.push_back(b1);
  endtask

  // Drives one request when the unit is ready; returns just after the accepting edge.
  task automatic do_store(input logic [2:0] f3, input logic [9:0] addr, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      return;
    end
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = addr;
    req_data   = data;
    push_expected(f3, addr, data);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every accepted beat and every error pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid && mem_ready) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 64'd1, 64'd0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_addr", 64'(mem_address), 64'(b.addr));
          check("beat_mask", 64'(mem_write_mask), 64'(b.mask));
          check("beat_data", 64'(data_to_mem), 64'(b.data));
        end
      end
      if (req_err) begin
        if (err_pending == 0) begin
          check("err_unexpected", 64'd1, 64'd0);
        end else begin
          err_pending--;
          check("err_no_beat", 64'(mem_valid), 64'd0);
        end
      end
    end
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_err", 64'(req_err), 64'd0);
    check("rst_mask", 64'(mem_write_mask), 64'd0);
    check("rst_data", 64'(data_to_mem), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // SB single beat, latency 1 and return to idle
    ready_set = 1'b1;
    do_store(3'b000, 10'h003, 32'h1234_5678);
    @(negedge clk);
    check("sb_mem_valid", 64'(mem_valid), 64'd1);
    check("sb_req_ready", 64'(req_ready), 64'd0);
    check("sb_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("sb_idle_valid", 64'(mem_valid), 64'd0);
    check("sb_idle_ready", 64'(req_ready), 64'd1);
    check("sb_idle_mask", 64'(mem_write_mask), 64'd0);
    check("sb_idle_data", 64'(data_to_mem), 64'd0);

    // SH held under backpressure for six cycles
    ready_set = 1'b0;
    do_store(3'b001, 10'h002, 32'hAABB_CCDD);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("sh_hold_valid", 64'(mem_valid), 64'd1);
      check("sh_hold_mask", 64'(mem_write_mask), 64'hC);
      check("sh_hold_data", 64'(data_to_mem), 64'hCCDD_0000);
      if (i == 4) begin
        @(posedge clk);
        #1;
        ready_set = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("sh_ready_back", 64'(req_ready), 64'd1);
    check("sh_valid_drop", 64'(mem_valid), 64'd0);

    // SW straddling a word boundary
    do_store(3'b010, 10'h006, 32'h1122_3344);
`ifdef PSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    check("sw_b0_valid", 64'(mem_valid), 64'd1);
    @(negedge clk);
    check("sw_b1_valid", 64'(mem_valid), 64'd1);
    check("sw_b1_addr", 64'(mem_address), 64'h008);
`else
    @(negedge clk);
    check("sw_err_pulse", 64'(req_err), 64'd1);
    check("sw_err_valid", 64'(mem_valid), 64'd0);
    @(negedge clk);
    check("sw_err_clear", 64'(req_err), 64'd0);
    check("sw_err_valid2", 64'(mem_valid), 64'd0);
`endif

    // SD and reserved funct3 are rejected on a 32-bit datapath
    do_store(3'b011, 10'h000, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sd_err_pulse", 64'(req_err), 64'd1);
    check("sd_err_valid", 64'(mem_valid), 64'd0);
    do_store(3'b100, 10'h010, 32'h0000_00FF);
    @(negedge clk);
    check("f3hi_err_pulse", 64'(req_err), 64'd1);

    // SW at top of address space: beat1 wraps to 0
    do_store(3'b010, 10'h3FE, 32'h1122_3344);
    @(negedge clk);
`ifdef PSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    check("wrap_addr", 64'(mem_address), 64'h000);
    check("wrap_mask", 64'(mem_write_mask), 64'h3);
`else
    check("wrap_err", 64'(req_err), 64'd1);
`endif
    @(negedge clk);

    // Reset while a beat is pending
`ifdef PSU_MISALIGN_SPLIT_EN
    ready_set = 1'b1;
    do_store(3'b010, 10'h006, 32'h5566_7788);
    @(posedge clk);
    #1;
    ready_set = 1'b0;
`else
    ready_set = 1'b0;
    do_store(3'b000, 10'h001, 32'h0000_00AB);
`endif
    @(negedge clk);
    check("abort_pre_valid", 64'(mem_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(mem_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mask", 64'(mem_write_mask), 64'd0);
    beat_q.delete();
    err_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_set = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_idle", 64'(busy), 64'd0);

    // Random stores with random memory backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [2:0] f3;
      r = $urandom_range(0, 9);
      if (r == 3)      f3 = 3'b011;
      else if (r == 4) f3 = {1'b1, 2'($urandom_range(0, 3))};
      else             f3 = {1'b0, 2'($urandom_range(0, 2))};
      do_store(f3, 10'($urandom), $urandom);
    end
    for (int i = 0; i < 300 && (busy || beat_q.size() != 0 || err_pending != 0); i++) @(negedge clk);
    check("drain_busy", 64'(busy), 64'd0);
    check("sb_beats_left", 64'(beat_q.size()), 64'd0);
    check("sb_errs_left", 64'(err_pending), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
